// File: rtl/count_sequence_checker.sv
// count_sequence_checker: watches a free-running up counter and checks that every
// sample is the previous one plus one (mod 2^WIDTH). It also tracks lock status and
// keeps saturating error and wrap statistics.
// Latency: every output is registered, so an event sampled at edge k shows just after edge k.
// Backpressure: none. The block samples count_in on every edge where en=1 and ignores it otherwise.
//
// Ports:
//   clk, rst       single rising-edge clock; asynchronous active-low reset
//   en, count_in   sample enable and the monitored count
//   clear          synchronous clear of err_count / wrap_count / err_sticky
//   locked         high while the FSM is in LOCKED
//   wrap_pulse     one-cycle pulse on a valid max->0 step while locked
//   err_pulse      one-cycle pulse on a sequence break while locked
//   err_sticky     set by any locked-state error, held until rst or clear
//   err_count      saturating count of locked-state errors
//   wrap_count     saturating count of locked-state wraps
//   last_count     most recently sampled count_in
module count_sequence_checker #(
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8,
  parameter int RESYNC_LEN = 2   // legal range 1..15 (good_run is 4 bits)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  clear,
  output logic                  locked,
  output logic                  wrap_pulse,
  output logic                  err_pulse,
  output logic                  err_sticky,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic [WIDTH-1:0]      last_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [3:0]       RESYNC_THR = 4'(RESYNC_LEN);

  state_t           state;
  logic [3:0]       good_run;
  logic [WIDTH-1:0] expected;
  logic [3:0]       good_run_inc;
  logic             match;
  logic             last_is_max;
  logic             lock_err;
  logic             lock_wrap;

  // The successor is computed in WIDTH bits, so max -> 0 counts as a match.
  assign expected     = last_count + ONE;
  assign match        = (count_in == expected);
  assign last_is_max  = &last_count;
  assign good_run_inc = good_run + 4'd1;

  // Events that drive the statistics. They only exist on an enabled sample in LOCKED.
  assign lock_err  = en && (state == LOCKED) && !match;
  assign lock_wrap = en && (state == LOCKED) && match && last_is_max;

  // Lock/resync FSM. The registered outputs locked, pulses and last_count live here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      good_run   <= 4'd0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      last_count <= '0;
    end else begin
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      if (en) begin
        last_count <= count_in;
        unique case (state)
          IDLE: begin
            // The first sample has no history to compare against.
            state    <= SYNC;
            good_run <= 4'd0;
            locked   <= 1'b0;
          end
          SYNC: begin
            if (match) begin
              if (good_run_inc == RESYNC_THR) begin
                state    <= LOCKED;
                good_run <= 4'd0;
                locked   <= 1'b1;
              end else begin
                good_run <= good_run_inc;
              end
            end else begin
              // An error while resyncing only restarts the run. It is not counted.
              good_run <= 4'd0;
            end
          end
          LOCKED: begin
            if (match) begin
              wrap_pulse <= last_is_max;
            end else begin
              err_pulse <= 1'b1;
              state     <= SYNC;
              good_run  <= 4'd0;
              locked    <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            good_run <= 4'd0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Statistics. The clear is assigned last, so it overrides a same-edge increment or set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count  <= '0;
      wrap_count <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (lock_err) begin
        err_sticky <= 1'b1;
        if (!(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
      end
      if (lock_wrap && !(&wrap_count)) begin
        wrap_count <= wrap_count + WRAP_CNT_W'(1);
      end
      if (clear) begin
        err_count  <= '0;
        wrap_count <= '0;
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_count_sequence_checker.sv
module tb_count_sequence_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic [3:0] count_in = '0;
  logic clear = 1'b0;

  // Default-parameter instance
  logic a_locked, a_wrap, a_err, a_sticky;
  logic [7:0] a_errc, a_wrapc;
  logic [3:0] a_last;
  // Saturation instance: ERR_CNT_W=2, RESYNC_LEN=1
  logic s_locked, s_wrap, s_err, s_sticky;
  logic [1:0] s_errc;
  logic [7:0] s_wrapc;
  logic [3:0] s_last;

  int n_cmp = 0;
  int n_bad = 0;
  int s_err_pulses = 0;
  int a_wrap_pulses = 0;

  always #5 clk = ~clk;

  count_sequence_checker dut_a (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clear(clear),
    .locked(a_locked), .wrap_pulse(a_wrap), .err_pulse(a_err), .err_sticky(a_sticky),
    .err_count(a_errc), .wrap_count(a_wrapc), .last_count(a_last)
  );

  count_sequence_checker #(.ERR_CNT_W(2), .RESYNC_LEN(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clear(clear),
    .locked(s_locked), .wrap_pulse(s_wrap), .err_pulse(s_err), .err_sticky(s_sticky),
    .err_count(s_errc), .wrap_count(s_wrapc), .last_count(s_last)
  );

  // Reference model state. st: 0=IDLE 1=SYNC 2=LOCKED.
  typedef struct {
    int st;
    int gr;
    int last;
    int errc;
    int wrapc;
    bit sticky;
    bit wrap;
    bit err;
  } model_t;

  model_t ma, ms;
  model_t qa[$];
  model_t qs[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t m;
    m.st = 0; m.gr = 0; m.last = 0; m.errc = 0; m.wrapc = 0;
    m.sticky = 0; m.wrap = 0; m.err = 0;
    return m;
  endfunction

  task automatic model_step(inout model_t m, input bit e, input int cnt, input bit clr,
                            input int rlen, input int emax, input int wmax);
    bit good;
    m.wrap = 0;
    m.err  = 0;
    if (e) begin
      good = (((m.last + 1) % 16) == cnt);
      case (m.st)
        0: begin m.st = 1; m.gr = 0; end
        1: begin
          if (good) begin
            m.gr = m.gr + 1;
            if (m.gr == rlen) begin m.st = 2; m.gr = 0; end
          end else m.gr = 0;
        end
        default: begin
          if (good) begin
            if (m.last == 15) begin
              m.wrap = 1;
              if (m.wrapc < wmax) m.wrapc = m.wrapc + 1;
            end
          end else begin
            m.err = 1;
            m.sticky = 1;
            if (m.errc < emax) m.errc = m.errc + 1;
            m.st = 1; m.gr = 0;
          end
        end
      endcase
      m.last = cnt;
    end
    if (clr) begin m.errc = 0; m.wrapc = 0; m.sticky = 0; end
  endtask

  // Drives one cycle, predicts the result, then checks it #1 after the edge.
  task automatic cyc(input bit e, input int cnt, input bit clr);
    model_t ea, es;
    @(negedge clk);
    en = e; count_in = 4'(cnt); clear = clr;
    model_step(ma, e, cnt, clr, 2, 255, 255);
    model_step(ms, e, cnt, clr, 1, 3, 255);
    qa.push_back(ma);
    qs.push_back(ms);
    @(posedge clk);
    #1;
    if (s_err) s_err_pulses++;
    if (a_wrap) a_wrap_pulses++;
    ea = qa.pop_front();
    es = qs.pop_front();
    chk("a.locked", int'(a_locked), int'(ea.st == 2));
    chk("a.wrap_pulse", int'(a_wrap), int'(ea.wrap));
    chk("a.err_pulse", int'(a_err), int'(ea.err));
    chk("a.err_sticky", int'(a_sticky), int'(ea.sticky));
    chk("a.err_count", int'(a_errc), ea.errc);
    chk("a.wrap_count", int'(a_wrapc), ea.wrapc);
    chk("a.last_count", int'(a_last), ea.last);
    chk("s.locked", int'(s_locked), int'(es.st == 2));
    chk("s.err_pulse", int'(s_err), int'(es.err));
    chk("s.err_count", int'(s_errc), es.errc);
    chk("s.last_count", int'(s_last), es.last);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".a.locked"}, int'(a_locked), 0);
    chk({tag, ".a.pulses"}, int'({a_wrap, a_err}), 0);
    chk({tag, ".a.sticky"}, int'(a_sticky), 0);
    chk({tag, ".a.counts"}, int'({a_errc, a_wrapc}), 0);
    chk({tag, ".a.last"}, int'(a_last), 0);
    chk({tag, ".s.all"}, int'({s_locked, s_wrap, s_err, s_sticky, s_errc, s_wrapc, s_last}), 0);
  endtask

  initial begin
    ma = model_reset();
    ms = model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Clean run 0..15,0,1
    for (int i = 0; i < 16; i++) cyc(1, i, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("clean.wrap_pulses", a_wrap_pulses, 1);

    // Skip error: ..5,6,8,9,10
    for (int i = 2; i <= 6; i++) cyc(1, i, 0);
    cyc(1, 8, 0);
    cyc(1, 9, 0);
    cyc(1, 10, 0);

    // Enable gating around last_count=3
    for (int i = 11; i <= 15; i++) cyc(1, i, 0);
    for (int i = 0; i <= 3; i++) cyc(1, i, 0);
    cyc(0, 9, 0);
    cyc(0, 12, 0);
    cyc(0, 1, 0);
    cyc(1, 4, 0);

    // Clear on the same edge as a valid wrap
    for (int i = 5; i <= 15; i++) cyc(1, i, 0);
    cyc(1, 0, 1);
    cyc(1, 1, 0);

    // Saturation: five errors, each followed by one good sample
    s_err_pulses = 0;
    cyc(1, 5, 0);  cyc(1, 6, 0);
    cyc(1, 9, 0);  cyc(1, 10, 0);
    cyc(1, 13, 0); cyc(1, 14, 0);
    cyc(1, 1, 0);  cyc(1, 2, 0);
    cyc(1, 7, 0);  cyc(1, 8, 0);
    chk("sat.err_pulses", s_err_pulses, 5);
    chk("sat.err_count", int'(s_errc), 3);

    // Async reset mid-lock
    cyc(1, 9, 0);
    cyc(1, 10, 0);
    chk("prereset.locked", int'(a_locked), 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    count_in = 4'd3;
    #1;
    chk_all_zero("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      count_in = 4'(i * 5);
      en = 1'b1;
      @(posedge clk);
      #1;
      chk_all_zero("held_rst");
    end
    @(negedge clk);
    rst = 1'b1;
    ma = model_reset();
    ms = model_reset();
    cyc(1, 4, 0);
    cyc(1, 5, 0);
    cyc(1, 6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/count_sequence_checker.md
# count_sequence_checker

Monitor stage that sits directly downstream of the team's free-running up counter and consumes its count output every enabled cycle. It checks that each sampled value equals the previous value plus one, modulo 2^WIDTH. A lock/resync state machine tracks this, and the block keeps saturating statistics on wrap-arounds and sequence errors. It gives the bench and on-chip debug a self-checking view of counter health.

## Interface
- WIDTH, 4, width of the monitored count
- ERR_CNT_W, 8, width of the saturating error counter
- WRAP_CNT_W, 8, width of the saturating wrap counter
- RESYNC_LEN, 2, consecutive good increments required to (re)acquire lock; legal range 1..15
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  sample enable; count_in is sampled only on edges where en=1
- count_in  input  WIDTH  count value from the upstream counter
- clear  input  1  synchronous clear of statistics (err_count, wrap_count, err_sticky)
- locked  output  1  high while state is LOCKED
- wrap_pulse  output  1  one-cycle pulse: valid wrap (2^WIDTH-1 -> 0) seen while LOCKED
- err_pulse  output  1  one-cycle pulse: sequence error seen while LOCKED
- err_sticky  output  1  set on any error; cleared only by rst or clear
- err_count  output  ERR_CNT_W  number of errors, saturating at all-ones
- wrap_count  output  WRAP_CNT_W  number of wraps, saturating at all-ones
- last_count  output  WIDTH  most recently sampled count_in

## Operation
- States: IDLE, SYNC, LOCKED. The good_run counter (4 bits) is internal.
- Match means count_in == last_count + 1, computed in WIDTH bits, so max -> 0 is a match.
- Every sample (en=1) loads count_in into last_count, in all states.
- IDLE: the first sample moves the block to SYNC with good_run=0. No compare is made, because there is no history.
- SYNC:
  - Match: good_run+1. When the incremented value reaches RESYNC_LEN, go to LOCKED and reset good_run to 0.
  - Mismatch: good_run=0. No err_pulse and no counting.
- LOCKED:
  - Match: stay in LOCKED. If last_count was all-ones, assert wrap_pulse and increment wrap_count (saturating).
  - Mismatch: assert err_pulse, increment err_count (saturating), set err_sticky, go to SYNC with good_run=0.
- A reset of the upstream counter while LOCKED (nonzero -> 0, not from max) is an error by definition.
- en=0: state, good_run, last_count and statistics hold. Both pulses are 0.
- clear=1: err_count, wrap_count and err_sticky go to 0 on that edge. Clear beats a same-edge increment or set. Pulses and the FSM are unaffected by clear.
- Async reset (rst=0), at any time including mid-lock:
  - state=IDLE
  - all outputs 0, last_count=0, good_run=0

## Timing
- All outputs are registered. An event sampled at edge k is visible from just after edge k until edge k+1.
- Pulses are exactly one cycle wide. Back-to-back events give back-to-back pulses.
- Lock latency: with en held high after reset release, locked rises at the (RESYNC_LEN+1)-th sampling edge. With the default, that is the 3rd.
- Relock after an error: RESYNC_LEN further good samples.
- Reset deassertion is expected to be synchronised externally. No sample is taken while rst=0.

## Test plan
- Reset: drive rst=0 mid-LOCKED with count_in toggling -> all outputs 0 immediately (asynchronously) and stay 0 until rst=1; then first sample -> SYNC, locked=0.
- Clean run, defaults: en=1, feed 0,1,...,15,0,1 -> locked=1 from the edge sampling 2; wrap_pulse exactly once, on the edge sampling 0 after 15; wrap_count=1; err_count=0; err_sticky=0.
- Skip error: while locked, feed 5,6,8,9,10 -> err_pulse on the 8 edge; err_count=1; err_sticky=1; locked=0; locked=1 again on the 10 edge.
- Enable gating: locked at last_count=3; en=0 for 3 cycles while count_in shows 9,12,1 -> no pulses, last_count=3; en=1 with count_in=4 -> still locked, no error.
- Clear priority: clear=1 on the same edge as a valid 15->0 wrap -> wrap_pulse=1, wrap_count=0; err_sticky=0.
- Saturation: ERR_CNT_W=2, RESYNC_LEN=1; create 5 errors, each followed by one good sample -> err_count stops at 3; err_pulse still fires 5 times.
